array_mux_arbiter: RTL and testbench

Shared-access controller for the 8-entry × 8-bit lookup array that feeds the 3-bit-select output mux. Owns the array storage and arbitrates read/write accesses from NUM_REQ requesters, at most one access per cycle. Arbitration is round-robin, with an optional per-requester lock for atomic bursts. Reads return on a registered response bus one cycle after acceptance.

---
 rtl/array_mux_pkg.sv | 15 +
 rtl/array_mux_arbiter_rr.sv | 29 ++
 rtl/array_mux_arbiter.sv | 167 ++++++++++++++++
 tb/tb_array_mux_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_mux_pkg.sv
// Shared types and default sizing for the lookup-array access controller.
package array_mux_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam int unsigned DEF_NUM_REQ  = 4;
    localparam int unsigned DEF_DEPTH    = 8;
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_INIT_VAL = 10;
    localparam int unsigned DEF_LOCK_MAX = 16;

endpackage

// File: rtl/array_mux_arbiter_rr.sv
// Combinational rotating-priority picker: first active request at or after ptr, with wrap.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int cand;
        cand = 0;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        for (int off = 0; off < int'(N); off++) begin
            cand = (int'(ptr) + off) % int'(N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/array_mux_arbiter.sv
// Owns the lookup array and grants one read/write access per cycle, round-robin with
// optional owner lock (force-released after LOCK_MAX idle owner cycles).
module array_mux_arbiter
    import array_mux_pkg::*;
#(
    parameter  int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    parameter  int unsigned WIDTH    = DEF_WIDTH,
    parameter  int unsigned INIT_VAL = DEF_INIT_VAL,
    parameter  int unsigned LOCK_MAX = DEF_LOCK_MAX,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 xfer;
    logic [IDX_W-1:0]     xfer_idx;
    logic                 sel_we;
    logic                 sel_lock;
    logic [ADDR_W-1:0]    sel_addr;
    logic [WIDTH-1:0]     sel_wdata;
    logic                 addr_ok;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (32'(i) + 32'd1 == NUM_REQ) ? '0 : i + IDX_W'(1);
    endfunction

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Grant and transfer select; in LOCK only the owner may be granted.
    always_comb begin
        req_ready = '0;
        xfer      = 1'b0;
        xfer_idx  = '0;
        if (state_q == ARB) begin
            req_ready = arb_gnt;
            xfer      = arb_any;
            xfer_idx  = arb_idx;
        end else begin
            req_ready[owner_q] = req_valid[owner_q];
            xfer               = req_valid[owner_q];
            xfer_idx           = owner_q;
        end
    end

    assign sel_we    = req_we[xfer_idx];
    assign sel_lock  = req_lock[xfer_idx];
    assign sel_addr  = req_addr[32'(xfer_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[32'(xfer_idx)*WIDTH +: WIDTH];
    assign addr_ok   = 32'(sel_addr) < DEPTH;

    // Next-state: lock entry/renewal/release and the idle timeout.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ARB: begin
                if (xfer) begin
                    if (sel_lock) begin
                        state_d    = LOCK;
                        owner_d    = xfer_idx;
                        idle_cnt_d = '0;
                    end else begin
                        rr_ptr_d = next_idx(xfer_idx);
                    end
                end
            end
            LOCK: begin
                if (xfer) begin
                    if (sel_lock) begin
                        idle_cnt_d = '0;
                    end else begin
                        state_d  = ARB;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end else if (32'(idle_cnt_q) == LOCK_MAX - 1) begin
                    state_d    = ARB;
                    rr_ptr_d   = next_idx(owner_q);
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
        endcase
        busy_d = (state_d == LOCK);
    end

    // Array write and read-response capture; out-of-range reads return zero.
    always_comb begin
        mem_d       = mem_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (xfer) begin
            if (sel_we) begin
                if (addr_ok) begin
                    mem_d[sel_addr] = sel_wdata;
                end
            end else begin
                rsp_valid_d[xfer_idx] = 1'b1;
                rsp_data_d            = addr_ok ? mem_q[sel_addr] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            idle_cnt_q  <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= WIDTH'(INIT_VAL);
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            idle_cnt_q  <= idle_cnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mem_q       <= mem_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_array_mux_arbiter.sv
// Bench for array_mux_arbiter: directed vector table, lock/timeout/reset sequences,
// and random traffic checked against a rule-level model.
module tb_array_mux_arbiter;

    localparam int N        = 4;
    localparam int DEPTH    = 8;
    localparam int INIT     = 10;
    localparam int LOCK_MAX = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, req_we, req_lock, rsp_valid;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  rsp_data;
    logic        busy;

    always #5 clk = ~clk;

    array_mux_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: contents, pointer, lock ownership and idle count as plain ints.
    int         m_mem [DEPTH];
    int         m_ptr, m_owner, m_idle;
    bit         m_locked;
    logic [3:0] m_ready, m_rsp_valid;
    logic [7:0] m_rsp_data;
    logic       m_busy;

    logic [3:0] a_rdy, a_rv;
    logic [7:0] a_rd;
    logic       a_bz;

    typedef struct {
        bit          rst_before;
        logic [3:0]  v, we, lk;
        logic [11:0] ad;
        logic [31:0] wd;
        logic [3:0]  e_rdy, e_rv;
        logic [7:0]  e_rd;
        logic        e_bz;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
        m_ptr       = 0;
        m_owner     = 0;
        m_idle      = 0;
        m_locked    = 1'b0;
        m_rsp_data  = 8'h00;
        m_rsp_valid = 4'h0;
        m_busy      = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] v, input logic [3:0] we,
                                       input logic [3:0] lk, input logic [11:0] ad,
                                       input logic [31:0] wd);
        int g;
        int a;
        g = -1;
        if (!m_locked) begin
            for (int off = 0; off < N; off++) begin
                if (g < 0 && v[(m_ptr + off) % N]) g = (m_ptr + off) % N;
            end
        end else if (v[m_owner]) begin
            g = m_owner;
        end
        m_ready     = 4'h0;
        m_rsp_valid = 4'h0;
        if (g >= 0) begin
            m_ready[g] = 1'b1;
            a = int'(ad[3*g +: 3]);
            if (we[g]) begin
                if (a < DEPTH) m_mem[a] = int'(wd[8*g +: 8]);
            end else begin
                m_rsp_valid[g] = 1'b1;
                m_rsp_data     = (a < DEPTH) ? 8'(m_mem[a]) : 8'h00;
            end
            if (!m_locked) begin
                if (lk[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                    m_idle   = 0;
                end else begin
                    m_ptr = (g + 1) % N;
                end
            end else if (lk[g]) begin
                m_idle = 0;
            end else begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % N;
            end
        end else if (m_locked) begin
            m_idle++;
            if (m_idle == LOCK_MAX) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
                m_idle   = 0;
            end
        end
        m_busy = m_locked;
    endfunction

    // Called at a falling edge; samples ready before the rising edge and responses just after.
    task automatic do_cycle(input logic [3:0] v, input logic [3:0] we, input logic [3:0] lk,
                            input logic [11:0] ad, input logic [31:0] wd);
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = ad;
        req_wdata = wd;
        #1;
        a_rdy = req_ready;
        model_step(v, we, lk, ad, wd);
        @(posedge clk);
        #1;
        a_rv = rsp_valid;
        a_rd = rsp_data;
        a_bz = busy;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        req_valid = 4'h0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic vec_t mk(input bit rb, input logic [3:0] v, input logic [3:0] we,
                                input logic [3:0] lk, input logic [11:0] ad,
                                input logic [31:0] wd, input logic [3:0] er,
                                input logic [3:0] ev, input logic [7:0] ed, input logic eb);
        vec_t r;
        r.rst_before = rb;
        r.v = v; r.we = we; r.lk = lk; r.ad = ad; r.wd = wd;
        r.e_rdy = er; r.e_rv = ev; r.e_rd = ed; r.e_bz = eb;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  rv, rw, rl;
        logic [11:0] ra;
        logic [31:0] rd;

        tbl[0]  = mk(0, 4'h1, 4'h0, 4'h0, 12'h005, 32'h0,        4'h1, 4'h1, 8'd10,  1'b0);
        tbl[1]  = mk(0, 4'h2, 4'h2, 4'h0, 12'h018, 32'h0000A500, 4'h2, 4'h0, 8'd10,  1'b0);
        tbl[2]  = mk(0, 4'h4, 4'h0, 4'h0, 12'h0C0, 32'h0,        4'h4, 4'h4, 8'hA5,  1'b0);
        tbl[3]  = mk(1, 4'hF, 4'h0, 4'h0, 12'h688, 32'h0,        4'h1, 4'h1, 8'd10,  1'b0);
        tbl[4]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h688, 32'h0,        4'h2, 4'h2, 8'd10,  1'b0);
        tbl[5]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h688, 32'h0,        4'h4, 4'h4, 8'd10,  1'b0);
        tbl[6]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h688, 32'h0,        4'h8, 4'h8, 8'd10,  1'b0);
        tbl[7]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h688, 32'h0,        4'h1, 4'h1, 8'd10,  1'b0);
        tbl[8]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h688, 32'h0,        4'h2, 4'h2, 8'd10,  1'b0);
        tbl[9]  = mk(0, 4'hF, 4'h0, 4'h4, 12'h688, 32'h0,        4'h4, 4'h4, 8'd10,  1'b1);
        tbl[10] = mk(0, 4'hF, 4'h4, 4'h4, 12'hDB6, 32'h003C0000, 4'h4, 4'h0, 8'd10,  1'b1);
        tbl[11] = mk(0, 4'hF, 4'h0, 4'h0, 12'hDB6, 32'h0,        4'h4, 4'h4, 8'h3C,  1'b0);
        tbl[12] = mk(0, 4'hF, 4'h0, 4'h0, 12'hDB6, 32'h0,        4'h8, 4'h8, 8'h3C,  1'b0);

        rst       = 1'b1;
        req_valid = 4'h0;
        req_we    = 4'h0;
        req_lock  = 4'h0;
        req_addr  = 12'h0;
        req_wdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_data",  32'(rsp_data),  32'h0);
        check("reset_busy",      32'(busy),      32'h0);
        check("reset_ready",     32'(req_ready), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst_before) pulse_reset();
            do_cycle(tbl[i].v, tbl[i].we, tbl[i].lk, tbl[i].ad, tbl[i].wd);
            check($sformatf("vec%0d_ready", i),     32'(a_rdy), 32'(tbl[i].e_rdy));
            check($sformatf("vec%0d_rsp_valid", i), 32'(a_rv),  32'(tbl[i].e_rv));
            check($sformatf("vec%0d_rsp_data", i),  32'(a_rd),  32'(tbl[i].e_rd));
            check($sformatf("vec%0d_busy", i),      32'(a_bz),  32'(tbl[i].e_bz));
        end

        // Requester 1 locks then goes idle; requester 2 must wait out the timeout.
        do_cycle(4'h2, 4'h0, 4'h2, 12'h000, 32'h0);
        check("tmo_lock_ready", 32'(a_rdy), 32'h2);
        check("tmo_lock_busy",  32'(a_bz),  32'h1);
        for (int k = 1; k <= LOCK_MAX; k++) begin
            do_cycle(4'h4, 4'h0, 4'h0, 12'h180, 32'h0);
            check($sformatf("tmo_idle%0d_ready", k), 32'(a_rdy), 32'h0);
            check($sformatf("tmo_idle%0d_rsp", k),   32'(a_rv),  32'h0);
            check($sformatf("tmo_idle%0d_busy", k),  32'(a_bz),  (k < LOCK_MAX) ? 32'h1 : 32'h0);
        end
        do_cycle(4'h4, 4'h0, 4'h0, 12'h180, 32'h0);
        check("tmo_after_ready", 32'(a_rdy), 32'h4);
        check("tmo_after_rsp",   32'(a_rv),  32'h4);
        check("tmo_after_data",  32'(a_rd),  32'h3C);

        // Reset right after a read transfer must clear the pending pulse at once.
        req_valid = 4'h1;
        req_we    = 4'h0;
        req_lock  = 4'h0;
        req_addr  = 12'h001;
        @(posedge clk);
        #1;
        check("rst_pre_rsp_valid", 32'(rsp_valid), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_async_rsp_data",  32'(rsp_data),  32'h0);
        @(negedge clk);
        req_valid = 4'h0;
        rst = 1'b0;
        model_reset();
        ra = 12'($urandom_range(0, 7));
        do_cycle(4'h1, 4'h0, 4'h0, ra, 32'h0);
        check("post_rst_rsp_valid", 32'(a_rv), 32'h1);
        check("post_rst_rsp_data",  32'(a_rd), 32'd10);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rv = 4'($urandom);
            rw = 4'($urandom);
            rl = 4'h0;
            for (int b = 0; b < N; b++) rl[b] = ($urandom_range(0, 3) == 0);
            ra = 12'($urandom);
            rd = $urandom;
            do_cycle(rv, rw, rl, ra, rd);
            check("rnd_ready",     32'(a_rdy), 32'(m_ready));
            check("rnd_rsp_valid", 32'(a_rv),  32'(m_rsp_valid));
            check("rnd_rsp_data",  32'(a_rd),  32'(m_rsp_data));
            check("rnd_busy",      32'(a_bz),  32'(m_busy));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
